// File: rtl/haze_pkg.sv
// Register map, control/status bit positions and width helpers shared by the
// haze PI servo block and its sub-modules.
package haze_pkg;

  localparam logic [15:0] ADDR_SETPOINT    = 16'h100;
  localparam logic [15:0] ADDR_KI          = 16'h104;
  localparam logic [15:0] ADDR_KP          = 16'h108;
  localparam logic [15:0] ADDR_CTRL        = 16'h10C;
  localparam logic [15:0] ADDR_OUT_MIN     = 16'h110;
  localparam logic [15:0] ADDR_OUT_MAX     = 16'h114;
  localparam logic [15:0] ADDR_INT         = 16'h118;
  localparam logic [15:0] ADDR_STATUS      = 16'h11C;
  localparam logic [15:0] ADDR_PSR         = 16'h200;
  localparam logic [15:0] ADDR_ISR         = 16'h204;
  localparam logic [15:0] ADDR_GAINBITS    = 16'h20C;
  localparam logic [15:0] ADDR_DW          = 16'h210;
  localparam logic [15:0] ADDR_FILTERMINBW = 16'h228;

  localparam int CTRL_INT_RST  = 0;
  localparam int CTRL_INT_HOLD = 1;

  localparam int ST_AT_MAX  = 0;
  localparam int ST_AT_MIN  = 1;
  localparam int ST_INT_SAT = 2;
  localparam int ST_W       = 3;

  // Integrator keeps DW integer bits above ISR fractional bits.
  function automatic int haze_iw(input int dw, input int isr);
    return dw + isr;
  endfunction

endpackage

// File: rtl/red_pitaya_haze_sat.sv
// Signed saturating truncation from IN_W to OUT_W bits (IN_W > OUT_W).
module red_pitaya_haze_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);

  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = in_i[IN_W-1:OUT_W-1];

  // Value fits when every bit above the kept sign bit equals it.
  always_comb begin
    if ((&top_bits) || !(|top_bits)) out_o = in_i[OUT_W-1:0];
    else if (in_i[IN_W-1])           out_o = MIN_V;
    else                             out_o = MAX_V;
  end

endmodule

// File: rtl/red_pitaya_haze_pi_block.sv
// Pipelined PI servo: setpoint subtraction, P and I gains, saturating
// integrator with anti-windup and programmable output limits (4-cycle latency).
module red_pitaya_haze_pi_block
  import haze_pkg::*;
#(
  parameter int DW          = 14,
  parameter int GAINBITS    = 24,
  parameter int PSR         = 12,
  parameter int ISR         = 32,
  parameter int FILTERMINBW = 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic signed [DW-1:0] dat_i,
  output logic signed [DW-1:0] dat_o,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  output logic                 ack,
  output logic [31:0]          rdata,
  input  logic [31:0]          wdata
);

  localparam int IW = haze_iw(DW, ISR);
  localparam int EW = DW + 1;
  localparam int PW = DW + 1 + GAINBITS;
  localparam int SW = DW + 2;
  localparam logic signed [IW-1:0] INT_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};

  // Bus: a wen or ren strobe is accepted in the cycle it is high; ack pulses
  // and (for ren) rdata updates one cycle later, for any address.
  logic                       ack_q;
  logic [31:0]                rdata_q, rd_d;
  logic [DW-1:0]              setpoint_q;
  logic signed [GAINBITS-1:0] ki_q, kp_q;
  logic [1:0]                 ctrl_q;
  logic signed [DW-1:0]       out_min_q, out_max_q;

  logic signed [EW-1:0] err_q, err_d, p_term_q, p_term_d;
  logic signed [PW-1:0] pm_q, pm_d, im_q, im_d, pm_sh;
  logic signed [IW-1:0] int_q, int_d, int_acc;
  logic signed [IW:0]   int_sum;
  logic signed [SW-1:0] sum, omax_ext, omin_ext, lim_hi, lim;
  logic signed [DW-1:0] dat_q, out_d;
  logic [ST_W-1:0]      status_q, status_d;
  logic                 int_wr, im_pos, windup;
  logic                 unused_wdata;

  assign unused_wdata = ^wdata[31:GAINBITS];
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign dat_o = dat_q;

  always_comb begin
    rd_d = '0;
    case (addr)
      ADDR_SETPOINT:    rd_d = {{(32-DW){setpoint_q[DW-1]}}, setpoint_q};
      ADDR_KI:          rd_d = {{(32-GAINBITS){ki_q[GAINBITS-1]}}, ki_q};
      ADDR_KP:          rd_d = {{(32-GAINBITS){kp_q[GAINBITS-1]}}, kp_q};
      ADDR_CTRL:        rd_d = {30'b0, ctrl_q};
      ADDR_OUT_MIN:     rd_d = {{(32-DW){out_min_q[DW-1]}}, out_min_q};
      ADDR_OUT_MAX:     rd_d = {{(32-DW){out_max_q[DW-1]}}, out_max_q};
      ADDR_INT:         rd_d = {{(32-DW){int_q[IW-1]}}, int_q[IW-1:ISR]};
      ADDR_STATUS:      rd_d = {{(32-ST_W){1'b0}}, status_q};
      ADDR_PSR:         rd_d = 32'(PSR);
      ADDR_ISR:         rd_d = 32'(ISR);
      ADDR_GAINBITS:    rd_d = 32'(GAINBITS);
      ADDR_DW:          rd_d = 32'(DW);
      ADDR_FILTERMINBW: rd_d = 32'(FILTERMINBW);
      default:          rd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      setpoint_q <= '0;
      ki_q       <= '0;
      kp_q       <= '0;
      ctrl_q     <= '0;
      out_min_q  <= {1'b1, {(DW-1){1'b0}}};
      out_max_q  <= {1'b0, {(DW-1){1'b1}}};
    end else begin
      ack_q <= wen | ren;
      if (ren) rdata_q <= rd_d;
      if (wen) begin
        case (addr)
          ADDR_SETPOINT: setpoint_q <= wdata[DW-1:0];
          ADDR_KI:       ki_q       <= wdata[GAINBITS-1:0];
          ADDR_KP:       kp_q       <= wdata[GAINBITS-1:0];
          ADDR_CTRL:     ctrl_q     <= wdata[1:0];
          ADDR_OUT_MIN:  out_min_q  <= wdata[DW-1:0];
          ADDR_OUT_MAX:  out_max_q  <= wdata[DW-1:0];
          default:       ;
        endcase
      end
    end
  end

  assign pm_sh   = pm_q >>> PSR;
  assign int_sum = {int_q[IW-1], int_q} + {{(IW+1-PW){im_q[PW-1]}}, im_q};
  assign int_wr  = wen && (addr == ADDR_INT);
  assign im_pos  = !im_q[PW-1] && (|im_q);
  assign windup  = (status_q[ST_AT_MAX] && im_pos) || (status_q[ST_AT_MIN] && im_q[PW-1]);

  red_pitaya_haze_sat #(.IN_W(PW), .OUT_W(EW)) u_sat_p (
    .in_i  (pm_sh),
    .out_o (p_term_d)
  );

  red_pitaya_haze_sat #(.IN_W(IW+1), .OUT_W(IW)) u_sat_int (
    .in_i  (int_sum),
    .out_o (int_acc)
  );

  red_pitaya_haze_sat #(.IN_W(SW), .OUT_W(DW)) u_sat_out (
    .in_i  (lim),
    .out_o (out_d)
  );

  always_comb begin
    err_d    = {dat_i[DW-1], dat_i} - {setpoint_q[DW-1], setpoint_q};
    pm_d     = {{GAINBITS{err_q[DW]}}, err_q} * {{EW{kp_q[GAINBITS-1]}}, kp_q};
    im_d     = {{GAINBITS{err_q[DW]}}, err_q} * {{EW{ki_q[GAINBITS-1]}}, ki_q};
    sum      = {p_term_q[DW], p_term_q} + {{2{int_q[IW-1]}}, int_q[IW-1:ISR]};
    omax_ext = {{2{out_max_q[DW-1]}}, out_max_q};
    omin_ext = {{2{out_min_q[DW-1]}}, out_min_q};
    // Upper limit first so that out_min dominates when the limits cross.
    lim_hi   = (sum > omax_ext) ? omax_ext : sum;
    lim      = (lim_hi < omin_ext) ? omin_ext : lim_hi;

    status_d             = '0;
    status_d[ST_AT_MAX]  = sum > omax_ext;
    status_d[ST_AT_MIN]  = sum < omin_ext;
    status_d[ST_INT_SAT] = (int_q == INT_MAX) || (int_q == INT_MIN);

    int_d = int_q;
    if (ctrl_q[CTRL_INT_RST])                   int_d = '0;
    else if (int_wr)                            int_d = {wdata[DW-1:0], {ISR{1'b0}}};
    else if (!ctrl_q[CTRL_INT_HOLD] && !windup) int_d = int_acc;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      err_q    <= '0;
      pm_q     <= '0;
      im_q     <= '0;
      p_term_q <= '0;
      int_q    <= '0;
      dat_q    <= '0;
      status_q <= '0;
    end else begin
      err_q    <= err_d;
      pm_q     <= pm_d;
      im_q     <= im_d;
      p_term_q <= p_term_d;
      int_q    <= int_d;
      dat_q    <= out_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_haze_pi_block.sv
// Bench for the haze PI servo: directed scenarios plus randomized traffic,
// scored cycle by cycle against an integer-arithmetic reference model.
module tb_red_pitaya_haze_pi_block;

  localparam int DW = 14;
  localparam longint IMAX = (longint'(1) <<< 45) - 1;
  localparam longint IMIN = -(longint'(1) <<< 45);
  localparam longint ONE_I = longint'(1) <<< 32;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic signed [DW-1:0] dat_i;
  logic signed [DW-1:0] dat_o;
  logic [15:0]          addr;
  logic                 wen, ren, ack;
  logic [31:0]          rdata, wdata;

  red_pitaya_haze_pi_block dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .ack    (ack),
    .rdata  (rdata),
    .wdata  (wdata)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    longint r;
    r = longint'(v) & ((longint'(1) <<< w) - 1);
    if (r >= (longint'(1) <<< (w - 1))) r = r - (longint'(1) <<< w);
    return r;
  endfunction

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference model: samples travel through a delay line of plain integers.
  logic [DW-1:0] exp_q[$];
  longint m_sp, m_kp, m_ki, m_omin, m_omax;
  longint m_e1, m_pm2, m_im2, m_p3, m_int;
  logic [1:0]  m_ctrl;
  bit          m_amax, m_amin, m_isat, m_ack;
  logic [31:0] m_rdata;

  always @(posedge clk_i) begin : model
    longint sum, o, nint, rd;
    bit amax, amin, isat;
    if (!rstn_i) begin
      m_sp = 0; m_kp = 0; m_ki = 0; m_ctrl = 2'b00;
      m_omin = -8192; m_omax = 8191;
      m_e1 = 0; m_pm2 = 0; m_im2 = 0; m_p3 = 0; m_int = 0;
      m_amax = 0; m_amin = 0; m_isat = 0; m_ack = 0; m_rdata = '0;
      exp_q.push_back('0);
    end else begin
      sum  = m_p3 + (m_int >>> 32);
      o    = (sum > m_omax) ? m_omax : sum;
      if (o < m_omin) o = m_omin;
      amax = sum > m_omax;
      amin = sum < m_omin;
      isat = (m_int == IMAX) || (m_int == IMIN);

      nint = m_int;
      if (m_ctrl[0]) nint = 0;
      else if (wen && addr == 16'h118) nint = sx(wdata, 14) * ONE_I;
      else if (!m_ctrl[1] && !((m_amax && m_im2 > 0) || (m_amin && m_im2 < 0)))
        nint = clip(m_int + m_im2, IMIN, IMAX);

      case (addr)
        16'h100: rd = m_sp;
        16'h104: rd = m_ki;
        16'h108: rd = m_kp;
        16'h10C: rd = longint'(m_ctrl);
        16'h110: rd = m_omin;
        16'h114: rd = m_omax;
        16'h118: rd = m_int >>> 32;
        16'h11C: rd = longint'({m_isat, m_amin, m_amax});
        16'h200: rd = 12;
        16'h204: rd = 32;
        16'h20C: rd = 24;
        16'h210: rd = 14;
        16'h228: rd = 10;
        default: rd = 0;
      endcase
      m_ack = wen | ren;
      if (ren) m_rdata = rd[31:0];

      m_int  = nint;
      m_amax = amax; m_amin = amin; m_isat = isat;
      m_p3   = clip(m_pm2 >>> 12, -16384, 16383);
      m_pm2  = m_e1 * m_kp;
      m_im2  = m_e1 * m_ki;
      m_e1   = longint'(dat_i) - m_sp;

      if (wen) begin
        case (addr)
          16'h100: m_sp   = sx(wdata, 14);
          16'h104: m_ki   = sx(wdata, 24);
          16'h108: m_kp   = sx(wdata, 24);
          16'h10C: m_ctrl = wdata[1:0];
          16'h110: m_omin = sx(wdata, 14);
          16'h114: m_omax = sx(wdata, 14);
          default: ;
        endcase
      end
      exp_q.push_back(o[DW-1:0]);
    end
  end

  // Scoreboard: one expected output per clock edge, compared mid-cycle.
  always @(negedge clk_i) begin : scoreboard
    logic signed [DW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dat_o", longint'(dat_o), longint'(e));
      check("ack", longint'(ack), longint'(m_ack));
      check("rdata", longint'(rdata), longint'(m_rdata));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk_i);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0;
    d = rdata;
    check("rd_ack", longint'(ack), 1);
  endtask

  logic [15:0] addrs [14] = '{16'h100, 16'h104, 16'h108, 16'h10C, 16'h110,
                              16'h114, 16'h118, 16'h11C, 16'h200, 16'h204,
                              16'h20C, 16'h210, 16'h228, 16'h120};

  initial begin
    logic [31:0] d;
    rstn_i = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; dat_i = '0;
    tick(3);
    check("rst_dat_o", longint'(dat_o), 0);
    check("rst_ack", longint'(ack), 0);
    check("rst_rdata", longint'(rdata), 0);
    rstn_i = 1'b1;
    tick(1);
    bus_read(16'h114, d); check("out_max_rst", sx(d, 32), 8191);
    bus_read(16'h110, d); check("out_min_rst", sx(d, 32), -8192);
    bus_read(16'h20C, d); check("gainbits", longint'(d), 24);

    // Unity proportional gain, latency of exactly four edges.
    bus_write(16'h108, 32'h1000);
    tick(6);
    dat_i = 1000;
    tick(3); check("lat3", longint'(dat_o), 0);
    tick(1); check("lat4", longint'(dat_o), 1000);
    dat_i = -1000;
    tick(4); check("neg_unity", longint'(dat_o), -1000);

    // Double gain drives the output into the default limits.
    bus_write(16'h108, 32'h2000);
    dat_i = 5000;
    tick(6); check("sat_hi", longint'(dat_o), 8191);
    bus_read(16'h11C, d); check("at_max", longint'(d[0]), 1);
    dat_i = -5000;
    tick(6); check("sat_lo", longint'(dat_o), -8192);
    bus_read(16'h11C, d); check("at_min", longint'(d[1]), 1);

    // Pure integral action, then hold and reset of the integrator.
    bus_write(16'h108, 32'h0);
    dat_i = 1000;
    bus_write(16'h104, 32'h40_0000);
    tick(1030);
    bus_read(16'h118, d); check("i_term_rise", longint'(sx(d, 32) >= 1000 && sx(d, 32) <= 1010), 1);
    bus_write(16'h10C, 32'h2);
    tick(20);
    bus_read(16'h118, d);
    bus_write(16'h10C, 32'h1);
    tick(1);
    bus_read(16'h118, d); check("int_rst", sx(d, 32), 0);
    bus_write(16'h10C, 32'h0);

    // Tight output limits with anti-windup.
    bus_write(16'h114, 32'd100);
    bus_write(16'h110, 32'hFFFF_FF9C);
    tick(300); check("lim_100", longint'(dat_o), 100);
    bus_read(16'h118, d); check("windup", longint'(sx(d, 32) >= 100 && sx(d, 32) <= 103), 1);
    dat_i = -1000;
    tick(20);

    // Integrator preset, and preset masked by int_rst.
    bus_write(16'h104, 32'h0);
    bus_write(16'h110, 32'hFFFF_E000);
    bus_write(16'h114, 32'd8191);
    bus_write(16'h118, 32'd500);
    tick(6); check("preset", longint'(dat_o), 500);
    bus_write(16'h10C, 32'h1);
    bus_write(16'h118, 32'd700);
    bus_read(16'h118, d); check("preset_rst", sx(d, 32), 0);
    bus_write(16'h10C, 32'h0);

    // Integrator clipping at its own bounds.
    bus_write(16'h100, 32'h2000);
    dat_i = 8191;
    bus_write(16'h104, 32'h7F_FFFF);
    bus_write(16'h118, 32'd8191);
    tick(10);
    bus_read(16'h11C, d); check("int_sat", longint'(d), 4);
    bus_write(16'h104, 32'h0);
    bus_write(16'h100, 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      dat_i = 14'($urandom());
      wen   = ($urandom_range(0, 7) == 0);
      ren   = ($urandom_range(0, 3) == 0);
      addr  = addrs[$urandom_range(0, 13)];
      wdata = $urandom();
      if (addr == 16'h10C)
        wdata = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
      if ((addr == 16'h104 || addr == 16'h108) && $urandom_range(0, 1) == 1)
        wdata = 32'($urandom_range(0, 16'h3FFF));
      @(negedge clk_i);
    end
    wen = 1'b0; ren = 1'b0;

    // Reset in the middle of accumulation.
    bus_write(16'h10C, 32'h0);
    bus_write(16'h108, 32'h1000);
    bus_write(16'h104, 32'h40_0000);
    dat_i = 1000;
    tick(50);
    rstn_i = 1'b0;
    tick(1);
    check("mid_rst_dat_o", longint'(dat_o), 0);
    check("mid_rst_ack", longint'(ack), 0);
    rstn_i = 1'b1;
    bus_read(16'h108, d); check("mid_rst_kp", longint'(d), 0);
    bus_read(16'h104, d); check("mid_rst_ki", longint'(d), 0);
    bus_read(16'h114, d); check("mid_rst_omax", longint'(d), 8191);
    bus_read(16'h118, d); check("mid_rst_int", longint'(d), 0);
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
